// File: rtl/regfile_scoreboard.sv
// Integer register file with two write ports, optional write-to-read bypass
// and a per-register pending scoreboard used by decode for load-use stalls.
//
// Handshake note: there is no valid/ready flow here. Every strobe (wr0_en,
// wr1_en, sb_set_en) is a single-cycle command that takes effect at the
// rising edge it is sampled on; reads are pure combinational lookups.
module regfile_scoreboard #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGS     = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int WRITE_BYPASS = 1,
    localparam int ADDR_W      = $clog2(NUM_REGS),
    localparam int CNT_W       = $clog2(NUM_REGS + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_RD_PORTS*ADDR_W-1:0]     rd_addr,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD_PORTS-1:0]            rd_busy,
    input  logic                               wr0_en,
    input  logic [ADDR_W-1:0]                  wr0_addr,
    input  logic [DATA_WIDTH-1:0]              wr0_data,
    input  logic                               wr1_en,
    input  logic [ADDR_W-1:0]                  wr1_addr,
    input  logic [DATA_WIDTH-1:0]              wr1_data,
    input  logic                               sb_set_en,
    input  logic [ADDR_W-1:0]                  sb_set_addr,
    output logic [NUM_REGS-1:0]                pending_mask,
    output logic [CNT_W-1:0]                   pending_count,
    output logic                               wr_collision,
    output logic [NUM_REGS*DATA_WIDTH-1:0]     reg_dump
);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_pending;
    logic [CNT_W-1:0]      r_count;
    logic                  r_collision;

    logic                  w_wr0_act;
    logic                  w_wr1_act;
    logic                  w_sb_act;
    logic                  w_collide;
    logic [NUM_REGS-1:0]   w_pend_next;
    logic [CNT_W-1:0]      w_count_next;

    // Writes and sets aimed at x0 are dropped here so x0 can never change or go pending.
    assign w_wr0_act = wr0_en && (wr0_addr != '0);
    assign w_wr1_act = wr1_en && (wr1_addr != '0);
    assign w_sb_act  = sb_set_en && (sb_set_addr != '0);
    assign w_collide = w_wr0_act && w_wr1_act && (wr0_addr == wr1_addr);

    // Register array update; wr0 has priority when both ports hit the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_wr0_act && (wr0_addr == ADDR_W'(i))) begin
                    r_regs[i] <= wr0_data;
                end else if (w_wr1_act && (wr1_addr == ADDR_W'(i))) begin
                    r_regs[i] <= wr1_data;
                end
            end
        end
    end

    // Next pending state (set beats clear) and its popcount, so both register on the same edge.
    always_comb begin
        w_pend_next = r_pending;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (w_sb_act && (sb_set_addr == ADDR_W'(i))) begin
                w_pend_next[i] = 1'b1;
            end else if (w_wr1_act && (wr1_addr == ADDR_W'(i))) begin
                w_pend_next[i] = 1'b0;
            end
        end
        w_pend_next[0] = 1'b0;
        w_count_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_count_next = w_count_next + CNT_W'(w_pend_next[i]);
        end
    end

    // Scoreboard, pending count and collision flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= '0;
            r_count     <= '0;
            r_collision <= 1'b0;
        end else begin
            r_pending   <= w_pend_next;
            r_count     <= w_count_next;
            r_collision <= w_collide;
        end
    end

    // Combinational read ports with optional same-cycle bypass of the winning write.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
            logic [ADDR_W-1:0]     a;
            logic [DATA_WIDTH-1:0] d;
            logic                  b;
            a = rd_addr[p*ADDR_W +: ADDR_W];
            d = r_regs[a];
            b = r_pending[a];
            if (WRITE_BYPASS != 0) begin
                if (w_wr1_act && (wr1_addr == a)) begin
                    d = wr1_data;
                    // Load data arriving now is usable unless a new load re-marks it.
                    if (!(w_sb_act && (sb_set_addr == a))) begin
                        b = 1'b0;
                    end
                end
                if (w_wr0_act && (wr0_addr == a)) begin
                    d = wr0_data;
                end
            end
            if (a == '0) begin
                d = '0;
                b = 1'b0;
            end
            rd_data[p*DATA_WIDTH +: DATA_WIDTH] = d;
            rd_busy[p] = b;
        end
    end

    // Flatten stored values for debug visibility; never bypassed.
    always_comb begin
        reg_dump = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_dump[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
        end
    end

    assign pending_mask  = r_pending;
    assign pending_count = r_count;
    assign wr_collision  = r_collision;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: one bypassing and one non-bypassing instance
// share all inputs; table of single-cycle vectors plus hand sequences.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data_nb;
  logic [1:0]  rd_busy, rd_busy_nb;
  logic        wr0_en, wr1_en, sb_set_en;
  logic [4:0]  wr0_addr, wr1_addr, sb_set_addr;
  logic [31:0] wr0_data, wr1_data;
  logic [31:0] pending_mask, pending_mask_nb;
  logic [5:0]  pending_count, pending_count_nb;
  logic        wr_collision, wr_collision_nb;
  logic [1023:0] reg_dump, reg_dump_nb;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] model [32];
  logic [31:0] exp_q [$];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  regfile_scoreboard #(.WRITE_BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .pending_mask(pending_mask), .pending_count(pending_count),
    .wr_collision(wr_collision), .reg_dump(reg_dump)
  );

  regfile_scoreboard #(.WRITE_BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .pending_mask(pending_mask_nb), .pending_count(pending_count_nb),
    .wr_collision(wr_collision_nb), .reg_dump(reg_dump_nb)
  );

  typedef struct {
    logic        w0_en; logic [4:0] w0_a; logic [31:0] w0_d;
    logic        w1_en; logic [4:0] w1_a; logic [31:0] w1_d;
    logic        sb_en; logic [4:0] sb_a;
    logic [4:0]  ra0;   logic [4:0] ra1;
    logic [31:0] e_rd0; logic [31:0] e_rd1; logic e_busy0;
    logic [31:0] e_mask; logic [5:0] e_cnt; logic e_coll;
  } vec_t;

  vec_t vecs [16];

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    sb_set_en = 1'b0; sb_set_addr = '0;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all_zero(input string nm);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("%s_dump_x%0d", nm, i), reg_dump[i*32 +: 32], 32'h0);
    end
    check({nm, "_mask"}, pending_mask, 32'h0);
    check({nm, "_count"}, {26'h0, pending_count}, 32'h0);
    check({nm, "_coll"}, {31'h0, wr_collision}, 32'h0);
  endtask

  initial begin
    // expected outputs worked out by hand from the register-file rules
    vecs[0]  = '{1'b1,5'd5,32'hDEADBEEF, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd5,5'd0,  32'hDEADBEEF,32'h0,1'b0,        32'h0,6'd0,1'b0};
    vecs[1]  = '{1'b1,5'd0,32'hFFFFFFFF, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd5,5'd0,  32'hDEADBEEF,32'h0,1'b0,        32'h0,6'd0,1'b0};
    vecs[2]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd0,5'd5,  32'h0,32'hDEADBEEF,1'b0,        32'h0,6'd0,1'b0};
    vecs[3]  = '{1'b1,5'd7,32'h11,       1'b1,5'd7,32'h22,1'b0,5'd0, 5'd7,5'd7,  32'h11,32'h11,1'b0,             32'h0,6'd0,1'b1};
    vecs[4]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd7,5'd5,  32'h11,32'hDEADBEEF,1'b0,       32'h0,6'd0,1'b0};
    vecs[5]  = '{1'b0,5'd0,32'h0,        1'b1,5'd9,32'hA5,1'b0,5'd0, 5'd9,5'd7,  32'hA5,32'h11,1'b0,             32'h0,6'd0,1'b0};
    vecs[6]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0, 1'b1,5'd3, 5'd3,5'd0,  32'h0,32'h0,1'b0,               32'h8,6'd1,1'b0};
    vecs[7]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0, 1'b1,5'd4, 5'd3,5'd0,  32'h0,32'h0,1'b1,               32'h18,6'd2,1'b0};
    vecs[8]  = '{1'b1,5'd3,32'h33,       1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd3,5'd0,  32'h33,32'h0,1'b1,              32'h18,6'd2,1'b0};
    vecs[9]  = '{1'b0,5'd0,32'h0,        1'b1,5'd3,32'h44,1'b0,5'd0, 5'd3,5'd4,  32'h44,32'h0,1'b0,              32'h10,6'd1,1'b0};
    vecs[10] = '{1'b0,5'd0,32'h0,        1'b1,5'd4,32'h55,1'b1,5'd4, 5'd4,5'd3,  32'h55,32'h44,1'b1,             32'h10,6'd1,1'b0};
    vecs[11] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0, 1'b1,5'd0, 5'd0,5'd4,  32'h0,32'h55,1'b0,              32'h10,6'd1,1'b0};
    vecs[12] = '{1'b0,5'd0,32'h0,        1'b1,5'd4,32'h66,1'b0,5'd0, 5'd4,5'd0,  32'h66,32'h0,1'b0,              32'h0,6'd0,1'b0};
    vecs[13] = '{1'b1,5'd0,32'h1,        1'b1,5'd0,32'h2, 1'b0,5'd0, 5'd0,5'd4,  32'h0,32'h66,1'b0,              32'h0,6'd0,1'b0};
    vecs[14] = '{1'b1,5'd10,32'hAAAA,    1'b1,5'd11,32'hBBBB,1'b0,5'd0,5'd10,5'd11,32'hAAAA,32'hBBBB,1'b0,       32'h0,6'd0,1'b0};
    vecs[15] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd10,5'd11,32'hAAAA,32'hBBBB,1'b0,         32'h0,6'd0,1'b0};

    // reset
    rst = 1'b1; rd_addr = '0; idle();
    tick(); tick();
    rst = 1'b0;
    check_all_zero("reset");

    // random writes with a reference model, read back through the scoreboard queue
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    for (int n = 0; n < 24; n++) begin
      wr0_en = 1'($urandom_range(0, 1)); wr0_addr = 5'($urandom_range(0, 31)); wr0_data = $urandom;
      wr1_en = 1'($urandom_range(0, 1)); wr1_addr = 5'($urandom_range(0, 31)); wr1_data = $urandom;
      sb_set_en = 1'($urandom_range(0, 1)); sb_set_addr = 5'($urandom_range(1, 31));
      if (wr1_en && wr1_addr != 5'd0) model[wr1_addr] = wr1_data;
      if (wr0_en && wr0_addr != 5'd0) model[wr0_addr] = wr0_data;
      tick();
    end
    idle();
    for (int a = 0; a < 32; a += 2) begin
      rd_addr = {5'(a + 1), 5'(a)};
      exp_q.push_back(model[a]);
      exp_q.push_back(model[a + 1]);
      #1;
      check($sformatf("rand_rd0_x%0d", a), rd_data[31:0], exp_q.pop_front());
      check($sformatf("rand_rd1_x%0d", a + 1), rd_data[63:32], exp_q.pop_front());
    end
    for (int a = 0; a < 32; a++) begin
      check($sformatf("rand_dump_x%0d", a), reg_dump[a*32 +: 32], model[a]);
    end
    tick();

    // one-cycle reset with random writes and sets in flight
    rst = 1'b1;
    wr0_en = 1'b1; wr0_addr = 5'($urandom_range(1, 31)); wr0_data = $urandom;
    wr1_en = 1'b1; wr1_addr = 5'($urandom_range(1, 31)); wr1_data = $urandom;
    sb_set_en = 1'b1; sb_set_addr = 5'($urandom_range(1, 31));
    tick();
    rst = 1'b0; idle();
    check_all_zero("rst_mid");

    // table-driven vectors
    for (int i = 0; i < 16; i++) begin
      wr0_en = vecs[i].w0_en; wr0_addr = vecs[i].w0_a; wr0_data = vecs[i].w0_d;
      wr1_en = vecs[i].w1_en; wr1_addr = vecs[i].w1_a; wr1_data = vecs[i].w1_d;
      sb_set_en = vecs[i].sb_en; sb_set_addr = vecs[i].sb_a;
      rd_addr = {vecs[i].ra1, vecs[i].ra0};
      #1;
      check($sformatf("v%0d_rd0", i), rd_data[31:0], vecs[i].e_rd0);
      check($sformatf("v%0d_rd1", i), rd_data[63:32], vecs[i].e_rd1);
      check($sformatf("v%0d_busy0", i), {31'h0, rd_busy[0]}, {31'h0, vecs[i].e_busy0});
      tick();
      check($sformatf("v%0d_mask", i), pending_mask, vecs[i].e_mask);
      check($sformatf("v%0d_count", i), {26'h0, pending_count}, {26'h0, vecs[i].e_cnt});
      check($sformatf("v%0d_coll", i), {31'h0, wr_collision}, {31'h0, vecs[i].e_coll});
    end
    idle();
    check("x7_stored", reg_dump[7*32 +: 32], 32'h11);
    check("x0_stored", reg_dump[31:0], 32'h0);

    // bypass vs. no bypass on a pending register (x9 holds A5)
    sb_set_en = 1'b1; sb_set_addr = 5'd9; rd_addr = {5'd0, 5'd9};
    tick();
    idle();
    wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'hC3;
    #1;
    check("byp_rd0", rd_data[31:0], 32'hC3);
    check("nobyp_rd0", rd_data_nb[31:0], 32'hA5);
    check("byp_busy0", {31'h0, rd_busy[0]}, 32'h0);
    check("nobyp_busy0", {31'h0, rd_busy_nb[0]}, 32'h1);
    tick();
    idle();
    check("after_byp_rd0", rd_data[31:0], 32'hC3);
    check("after_nobyp_rd0", rd_data_nb[31:0], 32'hC3);
    check("after_byp_mask", pending_mask, 32'h0);

    // fill the scoreboard, then x0 set, then reset with a set in flight
    for (int a = 1; a < 32; a++) begin
      sb_set_en = 1'b1; sb_set_addr = 5'(a);
      tick();
    end
    idle();
    check("full_count", {26'h0, pending_count}, 32'd31);
    check("full_mask", pending_mask, 32'hFFFFFFFE);
    rd_addr = {5'd0, 5'($urandom_range(1, 31))};
    #1;
    check("full_busy0", {31'h0, rd_busy[0]}, 32'h1);
    check("full_busy_x0", {31'h0, rd_busy[1]}, 32'h0);
    sb_set_en = 1'b1; sb_set_addr = 5'd0;
    tick();
    check("set_x0_count", {26'h0, pending_count}, 32'd31);
    check("set_x0_mask", pending_mask, 32'hFFFFFFFE);
    rst = 1'b1; sb_set_en = 1'b1; sb_set_addr = 5'd5;
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'h123;
    tick();
    rst = 1'b0; idle();
    check_all_zero("rst_set");

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
